// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, sequencer states and index-width helper.
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: single-digit BCD add with decimal correction and carry out.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       ci,
  output logic [3:0] s_d,
  output logic       co
);
  logic [4:0] t;
  logic [4:0] tc;
  assign t = {1'b0, a_d} + {1'b0, b_d} + {4'b0, ci};
  assign tc = t + {1'b0, BCD_CORR};
  assign co = t[4] | (t[3] & (t[2] | t[1]));
  assign s_d = co ? tc[3:0] : t[3:0];
endmodule

// File: rtl/bcd_serial_accum.sv
// bcd_serial_accum: multi-digit BCD adder, one digit per cycle LSD first.
// Carry is registered between digits; done pulses once the top digit is written.
module bcd_serial_accum
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [BCD_W*DIGITS-1:0] sum,
  output logic                  cout,
  output logic                  err
);
  localparam int W = BCD_W * DIGITS;
  localparam int IW = idx_w(DIGITS);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, cout_q, cout_d, err_q, err_d;
  logic [W-1:0] opa_q, opa_d, opb_q, opb_d, sum_q, sum_d;
  logic [3:0] dig_a, dig_b, dig_s;
  logic dig_co, last;
  assign dig_a = opa_q[idx_q*BCD_W +: BCD_W];
  assign dig_b = opb_q[idx_q*BCD_W +: BCD_W];
  assign last = idx_q == IW'(DIGITS - 1);
  bcd_digit_add u_add (
    .a_d(dig_a),
    .b_d(dig_b),
    .ci (carry_q),
    .s_d(dig_s),
    .co (dig_co)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    carry_d = carry_q;
    cout_d = cout_q;
    err_d = err_q;
    opa_d = opa_q;
    opb_d = opb_q;
    sum_d = sum_q;
    case (state_q)
      IDLE: if (start) begin
        opa_d = a;
        opb_d = b;
        carry_d = cin;
        sum_d = '0;
        err_d = 1'b0;
        cout_d = 1'b0;
        idx_d = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[idx_q*BCD_W +: BCD_W] = dig_s;
        carry_d = dig_co;
        err_d = err_q | (dig_a > BCD_MAX) | (dig_b > BCD_MAX);
        cout_d = last ? dig_co : cout_q;
        idx_d = last ? idx_q : idx_q + 1'b1;
        state_d = last ? FIN : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      err_q <= 1'b0;
      opa_q <= '0;
      opb_q <= '0;
      sum_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      err_q <= err_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      sum_q <= sum_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign sum = sum_q;
  assign cout = cout_q;
  assign err = err_q;
endmodule

// File: tb/tb_bcd_serial_accum.sv
// tb_bcd_serial_accum: directed vectors with a scoreboard queue checked on done.
module tb_bcd_serial_accum;
  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;
  typedef struct {
    logic [W-1:0] s;
    logic c;
    logic e;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, cout, err;
  logic [W-1:0] sum;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;

  bcd_serial_accum #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
        chk("err", 32'(err), 32'(e.e));
      end
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic [W-1:0] es, input logic ec, input logic ee);
    exp_t e;
    e.s = es;
    e.c = ec;
    e.e = ee;
    exp_q.push_back(e);
    a = ia;
    b = ib;
    cin = ic;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 20 && !done; k++) @(negedge clk);
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout_err", 32'({cout, err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("t1_busy_c%0d", k), 32'(busy), 32'(k <= 5));
      chk($sformatf("t1_done_c%0d", k), 32'(done), 32'(k == 5));
      @(negedge clk);
    end
    issue(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    wait_done();
    issue(16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    wait_done();
    issue(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    wait_done();
    issue(16'h0505, 16'h0505, 1'b0, 16'h1010, 1'b0, 1'b0);
    wait_done();
    issue(16'h00A0, 16'h0001, 1'b0, 16'h0101, 1'b0, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    chk("hold_sum", 32'(sum), 32'h0101);
    chk("hold_err", 32'(err), 32'd1);
    issue(16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0);
    a = 16'h9999;
    b = 16'h9999;
    cin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(16'h0808, 16'h0303, 1'b0, 16'h1111, 1'b0, 1'b0);
    wait_done();
    issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout_err", 32'({cout, err}), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(16'h2500, 16'h7500, 1'b1, 16'h0001, 1'b1, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
